// File: rtl/led_pkg.sv
// Shared constants and FSM state type for the LED frame buffer.
// Optional build macro: LED_FRAME_BUFFER_AUTO_CLEAR_EN (see led_frame_buffer.sv).
package led_pkg;

    localparam int LED_ROWS = 8;
    localparam int LED_COLS = 8;

    typedef enum logic {
        FILL        = 1'b0,
        COMMIT_WAIT = 1'b1
    } fb_state_t;

    localparam logic [LED_ROWS-1:0] ROW_LAST = 8'b10000000;

endpackage

// File: rtl/led_frame_buffer_if.sv
// Producer-side row write bus into the frame buffer back bank.
// A row transfers on a rising clk edge where wr_valid && wr_ready; while wr_valid is high
// and not yet accepted, the master holds wr_row, wr_data and wr_last stable.
interface led_frame_buffer_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    logic                      wr_valid;
    logic                      wr_ready;
    logic [$clog2(ROWS)-1:0]   wr_row;
    logic [COLS-1:0]           wr_data;
    logic                      wr_last;

    modport master (
        output wr_valid, wr_row, wr_data, wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_row, wr_data, wr_last,
        output wr_ready
    );
endinterface

// File: rtl/led_row_decode.sv
// One-hot to binary row index; valid is low for an all-zero or multi-hot select.
module led_row_decode #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         valid
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) idx = W'(i);
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign valid = (onehot != '0) && ((onehot & (onehot - N'(1))) == '0);

endmodule

// File: rtl/led_frame_buffer.sv
// Double-buffered frame store feeding the LED row scanner; banks swap only on the row-7 scan.
// Build macro LED_FRAME_BUFFER_AUTO_CLEAR_EN clears the retired bank on each swap.
module led_frame_buffer
    import led_pkg::*;
#(
    parameter int ROWS = LED_ROWS,
    parameter int COLS = LED_COLS
) (
    input  logic               clk,
    input  logic               rst,
    led_frame_buffer_if.slave  wr,
    input  logic [ROWS-1:0]    scan_row,
    output logic [COLS-1:0]    col,
    output logic               frame_pending,
    output logic               swap_done,
    output fb_state_t          dbg_state
);

    localparam int RW = $clog2(ROWS);
    localparam logic [ROWS-1:0] SCAN_LAST = {1'b1, {(ROWS-1){1'b0}}};

    fb_state_t       state_q, state_d;
    logic            front_sel_q, front_sel_d;
    logic            swap_done_q, swap_done_d;
    logic [COLS-1:0] bank_q [2][ROWS];
    logic [COLS-1:0] bank_d [2][ROWS];

    logic            accept;
    logic            swap;
    logic [RW-1:0]   row_idx;
    logic            row_valid;

    assign wr.wr_ready = (state_q == FILL);
    assign accept      = wr.wr_valid && (state_q == FILL);
    assign swap        = (state_q == COMMIT_WAIT) && (scan_row == SCAN_LAST);

    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        swap_done_d = 1'b0;
        bank_d      = bank_q;

        case (state_q)
            FILL: begin
                if (accept && wr.wr_last) state_d = COMMIT_WAIT;
            end
            COMMIT_WAIT: begin
                if (swap) begin
                    state_d     = FILL;
                    front_sel_d = ~front_sel_q;
                    swap_done_d = 1'b1;
`ifdef LED_FRAME_BUFFER_AUTO_CLEAR_EN
                    // The retiring front bank becomes the new back buffer, starting blank.
                    for (int r = 0; r < ROWS; r++) bank_d[front_sel_q][r] = '0;
`else
                    // The retiring front bank becomes the new back buffer with stale rows intact.
                    bank_d = bank_q;
`endif
                end
            end
            default: state_d = FILL;
        endcase

        if (accept) bank_d[~front_sel_q][wr.wr_row] = wr.wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            front_sel_q <= 1'b0;
            swap_done_q <= 1'b0;
            bank_q      <= '{default: '0};
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            swap_done_q <= swap_done_d;
            bank_q      <= bank_d;
        end
    end

    led_row_decode #(.N(ROWS), .W(RW)) u_row_decode (
        .onehot (scan_row),
        .idx    (row_idx),
        .valid  (row_valid)
    );

    // Blank on an invalid select so a glitching scanner never lights two rows' data.
    assign col           = row_valid ? bank_q[front_sel_q][row_idx] : '0;
    assign frame_pending = (state_q == COMMIT_WAIT);
    assign swap_done     = swap_done_q;
    assign dbg_state     = state_q;

endmodule
